adc_ser_tx: RTL and testbench
=============================

// Module: adc_ser_tx
// PURPOSE
//  Synthesisable ADS52J90-style LVDS-lane serializer: the transmit end of the adc_data link.
//  - Packs 2 x 12-bit samples per lane into a 24-bit frame, MSB first (even channel first).
//  - Emits one bit per dclk (SDR) on every lane, plus a frame clock.
//  - Used for FPGA loopback/self-test of the deserializer and as a board-level pattern source.
// PARAMETERS
//  LANES        32  number of serial data lanes
//  SAMPLE_W     12  bits per sample; frame length FRAME_W = 2*SAMPLE_W (24)
//  SYNC_FRAMES  16  sync-pattern frames sent after enable before RUN
// PORTS
//  dclk           in   1              bit clock; all logic on posedge
//  rst            in   1              synchronous, active-high reset
//  enable         in   1              start/stop transmission
//  mode           in   2              0 DATA, 1 RAMP, 2 FIXED, 3 DESKEW
//  fixed_pattern  in   SAMPLE_W       word sent on every channel in FIXED mode
//  s_data         in   2*LANES*SAMPLE_W  channel k at bits [k*SAMPLE_W +: SAMPLE_W]
//  s_valid        in   1              s_data valid
//  s_ready        out  1              buffer can accept s_data this cycle
//  ser_q          out  LANES          serial bit per lane
//  fclk           out  1              frame clock: 1 for first SAMPLE_W bits of frame, else 0
//  frame_start    out  1              1 while ser_q carries bit 0 (MSB) of a frame
//  underrun       out  1              sticky: DATA frame started with empty buffer
//  clr_underrun   in   1              clears underrun
//  frame_cnt      out  16             frames sent since enable; wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: state IDLE; ser_q=0, fclk=0, frame_start=0, s_ready=0, underrun=0, frame_cnt=0;
//    buffer empty, ramp value 0, bit_cnt 0.
//  - FSM:
//    - IDLE: outputs 0. enable=1 -> SYNC; the frame load occurs in that transition cycle.
//    - SYNC: sends SYNC_FRAMES frames, every channel = 12'hFC0 (111111000000), then -> RUN.
//    - RUN: channel words per mode, chosen at each frame load.
//    - enable=0 in SYNC or RUN: the current frame completes; at its last bit -> IDLE
//      (no further load). Outputs are 0 from the next cycle.
//  - Frame timing:
//    - bit_cnt counts 0..FRAME_W-1; load_now = (bit_cnt==FRAME_W-1) in SYNC/RUN, or the
//      IDLE->SYNC cycle.
//    - On load_now, each lane shift register gets {ch[2j], ch[2j+1]}; otherwise it shifts left 1.
//    - ser_q[j] = shreg[j][FRAME_W-1], registered: the MSB appears the cycle after load_now.
//    - frame_start and fclk are aligned to ser_q.
//  - Input buffer: one frame deep.
//    - s_ready = (state!=IDLE) & (~buf_full | (load_now & RUN & mode==DATA)).
//    - Transfer occurs when s_valid & s_ready.
//    - Simultaneous consume and write at load_now is allowed; the buffer stays full with the
//      new data.
//    - Entering IDLE flushes the buffer. The buffer fills during SYNC.
//  - Modes:
//    - DATA: uses the buffer. If empty at load_now, all channels send 0 and underrun is set.
//    - RAMP: channel k = (ramp + k) mod 2^SAMPLE_W; ramp += 1 per frame, wrapping 4095->0.
//      ramp resets to 0 on entering SYNC.
//    - FIXED: every channel = fixed_pattern.
//    - DESKEW: every channel = 12'h555.
//    - mode is sampled only at load_now; mid-frame changes never corrupt a frame.
//  - frame_cnt increments at each load_now while not in IDLE; cleared on the IDLE->SYNC transition.
//  - underrun: set and clr_underrun in the same cycle -> set wins.
//  - rst mid-frame aborts immediately to reset values; there is no partial-frame completion.
// TESTING
//  - Reset, then enable=1 -> exactly 16 frames of 0xFC0 on all lanes.
//    - fclk period 24 cycles, high for 12.
//    - First MSB 1 cycle after enable is sampled.
//  - DATA mode, channel k = k+1 (as in the deserializer bench):
//    - lane 0 bits = {12'h001, 12'h002}, lane 31 = {12'h03F, 12'h040}.
//    - Loopback through adc_data recovers identical adc_data_out.
//  - DATA mode, s_valid withheld for one frame:
//    - that frame is all zeros on every lane; underrun=1 until clr_underrun.
//    - Next supplied frame is sent intact.
//  - RAMP: frame n lane 0 = {n, n+1} mod 4096.
//    - Check wrap at n=4095 -> {12'hFFF, 12'h000}, then {12'h000, 12'h001}.
//  - mode switched FIXED(0xABC)->DESKEW at bit 10 of a frame:
//    - that frame is fully 0xABC; the next frame is 0x555 on every channel.
//  - enable=0 at bit 5 of a frame -> frame completes 18 more bits, then ser_q=fclk=0 and s_ready=0.
//  - rst at bit 12 of a frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/adc_ser_tx_if.sv
// Sample-input handshake for adc_ser_tx: one full set of channel words per transfer.
interface adc_ser_tx_if #(
  parameter int unsigned LANES    = 32,
  parameter int unsigned SAMPLE_W = 12
);
  logic [2*LANES*SAMPLE_W-1:0] s_data;
  logic                        s_valid;
  logic                        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/adc_ser_tx.sv
// LVDS-lane serializer: packs two SAMPLE_W-bit channel words per lane into an MSB-first
// frame, one bit per dclk, with frame clock, sync preamble and test-pattern modes.
module adc_ser_tx #(
  parameter int unsigned LANES       = 32,
  parameter int unsigned SAMPLE_W    = 12,
  parameter int unsigned SYNC_FRAMES = 16
) (
  input  logic                dclk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [SAMPLE_W-1:0] fixed_pattern,
  adc_ser_tx_if.slave         s_if,
  output logic [LANES-1:0]    ser_q,
  output logic                fclk,
  output logic                frame_start,
  output logic                underrun,
  input  logic                clr_underrun,
  output logic [15:0]         frame_cnt
);

  localparam int unsigned FRAME_W = 2 * SAMPLE_W;
  localparam int unsigned CH      = 2 * LANES;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [1:0] MODE_DATA   = 2'd0;
  localparam logic [1:0] MODE_RAMP   = 2'd1;
  localparam logic [1:0] MODE_FIXED  = 2'd2;
  localparam logic [1:0] MODE_DESKEW = 2'd3;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] FCLK_BITS = CNT_W'(SAMPLE_W);
  localparam logic [15:0]      SYNC_LAST = 16'(SYNC_FRAMES - 1);

  // Upper half ones, lower half zeros (12'hFC0 at 12 bits).
  function automatic logic [SAMPLE_W-1:0] make_sync();
    logic [SAMPLE_W-1:0] w;
    for (int unsigned i = 0; i < SAMPLE_W; i++) w[i] = (i >= SAMPLE_W / 2);
    return w;
  endfunction

  // Alternating bits with bit 0 set (12'h555 at 12 bits).
  function automatic logic [SAMPLE_W-1:0] make_deskew();
    logic [SAMPLE_W-1:0] w;
    for (int unsigned i = 0; i < SAMPLE_W; i++) w[i] = ((i % 2) == 0);
    return w;
  endfunction

  localparam logic [SAMPLE_W-1:0] SYNC_WORD   = make_sync();
  localparam logic [SAMPLE_W-1:0] DESKEW_WORD = make_deskew();

  logic [1:0]                       state_q, state_d;
  logic [CNT_W-1:0]                 bit_cnt_q, bit_cnt_d;
  logic [15:0]                      frame_cnt_q, frame_cnt_d;
  logic [SAMPLE_W-1:0]              ramp_q, ramp_d;
  logic                             buf_full_q, buf_full_d;
  logic [2*LANES*SAMPLE_W-1:0]      buf_data_q, buf_data_d;
  logic                             underrun_q, underrun_d;
  logic [LANES-1:0][FRAME_W-1:0]    shreg_q, shreg_d;

  logic                             in_frame, frame_end, start, stop;
  logic                             sync_load, run_load, load_now;
  logic                             data_sel, consume, ready, wr;
  logic [CH-1:0][SAMPLE_W-1:0]      word;

  // Frame boundaries: the last sync frame's end loads the first RUN frame while still in SYNC.
  always_comb begin
    in_frame  = (state_q != ST_IDLE);
    frame_end = in_frame && (bit_cnt_q == BIT_LAST);
    start     = (state_q == ST_IDLE) && enable;
    stop      = frame_end && !enable;
    sync_load = start ||
                (frame_end && enable && (state_q == ST_SYNC) && (frame_cnt_q != SYNC_LAST));
    run_load  = frame_end && enable &&
                ((state_q == ST_RUN) || (frame_cnt_q == SYNC_LAST));
    load_now  = sync_load || run_load;
    data_sel  = run_load && (mode == MODE_DATA);
    consume   = data_sel && buf_full_q;
    ready     = in_frame && (!buf_full_q || data_sel);
    wr        = s_if.s_valid && ready;
  end

  assign s_if.s_ready = ready;

  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (sync_load) begin
        word[k] = SYNC_WORD;
      end else begin
        case (mode)
          MODE_DATA:   word[k] = buf_full_q ? buf_data_q[k*SAMPLE_W +: SAMPLE_W] : '0;
          MODE_RAMP:   word[k] = ramp_q + SAMPLE_W'(k);
          MODE_FIXED:  word[k] = fixed_pattern;
          MODE_DESKEW: word[k] = DESKEW_WORD;
          default:     word[k] = '0;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (start)         state_d = ST_SYNC;
    else if (stop)     state_d = ST_IDLE;
    else if (run_load) state_d = ST_RUN;

    bit_cnt_d = (in_frame && !frame_end) ? bit_cnt_q + CNT_W'(1) : '0;

    frame_cnt_d = frame_cnt_q;
    if (start)          frame_cnt_d = '0;
    else if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;

    ramp_d = ramp_q;
    if (start)                                   ramp_d = '0;
    else if (run_load && (mode == MODE_RAMP))    ramp_d = ramp_q + SAMPLE_W'(1);

    // A write in the same cycle as a consume leaves the buffer full with the new data.
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    if (stop) begin
      buf_full_d = 1'b0;
    end else if (wr) begin
      buf_full_d = 1'b1;
      buf_data_d = s_if.s_data;
    end else if (consume) begin
      buf_full_d = 1'b0;
    end

    underrun_d = (data_sel && !buf_full_q) || (underrun_q && !clr_underrun);

    for (int unsigned j = 0; j < LANES; j++) begin
      shreg_d[j] = load_now ? {word[2*j], word[2*j+1]} : {shreg_q[j][FRAME_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      ramp_q      <= '0;
      buf_full_q  <= 1'b0;
      buf_data_q  <= '0;
      underrun_q  <= 1'b0;
      shreg_q     <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      ramp_q      <= ramp_d;
      buf_full_q  <= buf_full_d;
      buf_data_q  <= buf_data_d;
      underrun_q  <= underrun_d;
      shreg_q     <= shreg_d;
    end
  end

  // The shift register drains to zero by the end of a stopped frame, so ser_q needs no gating.
  always_comb begin
    ser_q = '0;
    for (int unsigned j = 0; j < LANES; j++) ser_q[j] = shreg_q[j][FRAME_W-1];
  end

  assign fclk        = in_frame && (bit_cnt_q < FCLK_BITS);
  assign frame_start = in_frame && (bit_cnt_q == '0);
  assign underrun    = underrun_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_adc_ser_tx.sv
// Frame-level reference model with per-cycle output compare, plus literal frame checks.
module tb_adc_ser_tx;
  localparam int unsigned LANES = 32;
  localparam int unsigned SW    = 12;
  localparam int unsigned FW    = 24;
  localparam int unsigned CH    = 64;
  localparam int unsigned NSYNC = 16;

  typedef logic [SW-1:0] word_t;

  logic dclk = 1'b0;
  always #5 dclk = ~dclk;

  logic              rst, enable, clr_underrun;
  logic [1:0]        mode;
  logic [SW-1:0]     fixed_pattern;
  logic [LANES-1:0]  ser_q;
  logic              fclk, frame_start, underrun;
  logic [15:0]       frame_cnt;

  adc_ser_tx_if #(.LANES(LANES), .SAMPLE_W(SW)) s_if ();

  adc_ser_tx #(.LANES(LANES), .SAMPLE_W(SW), .SYNC_FRAMES(NSYNC)) dut (
    .dclk(dclk), .rst(rst), .enable(enable), .mode(mode), .fixed_pattern(fixed_pattern),
    .s_if(s_if.slave), .ser_q(ser_q), .fclk(fclk), .frame_start(frame_start),
    .underrun(underrun), .clr_underrun(clr_underrun), .frame_cnt(frame_cnt)
  );

  // Small instance: RAMP wrap at 2^SAMPLE_W within a short run.
  logic        rst2, en2;
  logic [1:0]  ser2;
  logic        fclk2, fs2, ur2;
  logic [15:0] fc2;
  adc_ser_tx_if #(.LANES(2), .SAMPLE_W(4)) s2_if ();
  assign s2_if.s_data  = '0;
  assign s2_if.s_valid = 1'b0;

  adc_ser_tx #(.LANES(2), .SAMPLE_W(4), .SYNC_FRAMES(2)) dut2 (
    .dclk(dclk), .rst(rst2), .enable(en2), .mode(2'd1), .fixed_pattern(4'h0),
    .s_if(s2_if.slave), .ser_q(ser2), .fclk(fclk2), .frame_start(fs2),
    .underrun(ur2), .clr_underrun(1'b0), .frame_cnt(fc2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level) ----------------
  word_t             m_frame [CH];
  logic [CH*SW-1:0]  m_buf [$];
  bit                m_act = 0, m_ok = 0, m_ur = 0;
  int                m_pos = 0, m_sent = 0, m_ramp = 0;
  logic [15:0]       m_fcnt = '0;

  function automatic bit exp_ready();
    if (!m_act) return 1'b0;
    if (m_buf.size() == 0) return 1'b1;
    return (m_pos == FW-1) && enable && (m_sent >= NSYNC) && (mode == 2'd0);
  endfunction

  function automatic logic [LANES-1:0] exp_ser();
    logic [LANES-1:0] r;
    r = '0;
    for (int j = 0; j < LANES; j++) begin
      logic [FW-1:0] f;
      f = {m_frame[2*j], m_frame[2*j+1]};
      r[j] = m_act & f[FW-1-m_pos];
    end
    return r;
  endfunction

  always @(posedge dclk) begin : model
    logic [CH*SW-1:0] popped;
    bit rdy, set;
    if (rst) begin
      m_act = 0; m_pos = 0; m_sent = 0; m_ramp = 0; m_fcnt = '0; m_ur = 0; m_ok = 1;
      m_buf.delete();
      for (int k = 0; k < CH; k++) m_frame[k] = '0;
    end else if (m_ok) begin
      rdy = exp_ready();
      set = 0;
      if (!m_act) begin
        if (enable) begin
          m_act = 1; m_pos = 0; m_fcnt = '0; m_ramp = 0; m_sent = 1;
          for (int k = 0; k < CH; k++) m_frame[k] = 12'hFC0;
        end
      end else if (m_pos != FW-1) begin
        m_pos++;
      end else begin
        m_fcnt++;
        if (!enable) begin
          m_act = 0;
        end else begin
          m_pos = 0;
          if (m_sent < NSYNC) begin
            m_sent++;
            for (int k = 0; k < CH; k++) m_frame[k] = 12'hFC0;
          end else begin
            case (mode)
              2'd0: if (m_buf.size() != 0) begin
                      popped = m_buf.pop_front();
                      for (int k = 0; k < CH; k++) m_frame[k] = popped[k*SW +: SW];
                    end else begin
                      for (int k = 0; k < CH; k++) m_frame[k] = '0;
                      set = 1;
                    end
              2'd1: begin
                      for (int k = 0; k < CH; k++) m_frame[k] = word_t'(m_ramp + k);
                      m_ramp = (m_ramp + 1) % 4096;
                    end
              2'd2: for (int k = 0; k < CH; k++) m_frame[k] = fixed_pattern;
              default: for (int k = 0; k < CH; k++) m_frame[k] = 12'h555;
            endcase
          end
        end
      end
      if (s_if.s_valid && rdy) m_buf.push_back(s_if.s_data);
      if (!m_act) m_buf.delete();
      m_ur = set | (m_ur & ~clr_underrun);
    end
  end

  always @(negedge dclk) begin
    #1;
    if (m_ok) begin
      chk("ser_q",       ser_q,       exp_ser());
      chk("fclk",        fclk,        m_act && (m_pos < SW));
      chk("frame_start", frame_start, m_act && (m_pos == 0));
      chk("s_ready",     s_if.s_ready, exp_ready());
      chk("underrun",    underrun,    m_ur);
      chk("frame_cnt",   frame_cnt,   m_fcnt);
    end
  end

  // ---------------- frame capture (lanes 0 / 31, small-instance lanes 0 / 1) ----------------
  logic [FW-1:0] sh0, sh31;
  logic [FW-1:0] cap0 [$], cap31 [$];
  int            cn = -1;
  always @(negedge dclk) begin
    if (frame_start) cn = 0;
    if (cn >= 0) begin
      sh0 = {sh0[FW-2:0], ser_q[0]};
      sh31 = {sh31[FW-2:0], ser_q[31]};
      cn++;
      if (cn == FW) begin cap0.push_back(sh0); cap31.push_back(sh31); cn = -1; end
    end
  end

  logic [7:0] s2a, s2b;
  logic [7:0] c2a [$], c2b [$];
  int         cn2 = -1;
  always @(negedge dclk) begin
    if (fs2) cn2 = 0;
    if (cn2 >= 0) begin
      s2a = {s2a[6:0], ser2[0]};
      s2b = {s2b[6:0], ser2[1]};
      cn2++;
      if (cn2 == 8) begin c2a.push_back(s2a); c2b.push_back(s2b); cn2 = -1; end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge dclk);
  endtask

  task automatic wait_fs();
    bit found;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge dclk);
      if (frame_start) begin found = 1; break; end
    end
    if (!found) chk("wait_frame_start_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH*SW-1:0] din;
    int f, g;
    rst = 1; enable = 0; mode = 2'd0; fixed_pattern = '0; clr_underrun = 0;
    s_if.s_valid = 0; s_if.s_data = '0; rst2 = 1; en2 = 0;
    tick(3);
    rst = 0; rst2 = 0;
    tick(1);
    chk("rst_ser_q", ser_q, 0);
    chk("rst_fclk", fclk, 0);
    chk("rst_ready", s_if.s_ready, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_underrun", underrun, 0);

    // DATA: channel k = k+1, offered continuously from enable on
    for (int k = 0; k < CH; k++) din[k*SW +: SW] = word_t'(k + 1);
    s_if.s_data = din; s_if.s_valid = 1; enable = 1;
    tick(1);
    chk("first_msb_fs", frame_start, 1);
    chk("first_msb_ser", ser_q, 32'hFFFF_FFFF);
    tick(16*FW);
    chk("run_fs", frame_start, 1);
    chk("run_frame_cnt", frame_cnt, 16);
    tick(2*FW);
    for (int i = 0; i < 16; i++) chk($sformatf("sync_frame%0d", i), cap0[i], 24'hFC0FC0);
    chk("data_l0", cap0[16], 24'h001002);
    chk("data_l31", cap31[16], 24'h03F040);

    // withhold s_valid for two frames: one buffered frame drains, next is an underrun
    s_if.s_valid = 0;
    tick(2*FW);
    chk("underrun_set", underrun, 1);
    for (int k = 0; k < CH; k++) din[k*SW +: SW] = word_t'(k + 12'h101);
    s_if.s_data = din; s_if.s_valid = 1;
    tick(2*FW);
    chk("underrun_held", underrun, 1);
    chk("drain_l0", cap0[19], 24'h001002);
    chk("zero_l0", cap0[20], 24'h0);
    chk("zero_l31", cap31[20], 24'h0);
    chk("resume_l0", cap0[21], 24'h101102);
    chk("resume_l31", cap31[21], 24'h13F140);
    clr_underrun = 1;
    tick(1);
    clr_underrun = 0;
    chk("underrun_clr", underrun, 0);

    // RAMP
    wait_fs();
    f = cap0.size();
    mode = 2'd1;
    tick(3*FW);
    chk("ramp0_l0", cap0[f+1], 24'h000001);
    chk("ramp0_l31", cap31[f+1], 24'h03E03F);
    chk("ramp1_l0", cap0[f+2], 24'h001002);

    // FIXED 0xABC, switched to DESKEW at bit 10 of the first FIXED frame
    g = cap0.size();
    chk("align_fixed", frame_start, 1);
    mode = 2'd2; fixed_pattern = 12'hABC;
    tick(FW + 10);
    mode = 2'd3;
    tick(14 + FW);
    chk("fixed_l0", cap0[g+1], 24'hABCABC);
    chk("fixed_l31", cap31[g+1], 24'hABCABC);
    chk("deskew_l0", cap0[g+2], 24'h555555);
    chk("deskew_l31", cap31[g+2], 24'h555555);

    // enable dropped at bit 5: frame completes, then idle
    chk("align_stop", frame_start, 1);
    tick(5);
    enable = 0;
    tick(18);
    chk("stop_last_bit", ser_q, 32'hFFFF_FFFF);
    chk("stop_last_fclk", fclk, 0);
    tick(1);
    chk("stop_ser_q", ser_q, 0);
    chk("stop_fclk", fclk, 0);
    chk("stop_ready", s_if.s_ready, 0);
    chk("stop_frame_done", cap0[cap0.size()-1], 24'h555555);
    tick(10);

    // rst at bit 12 of a frame
    mode = 2'd0; enable = 1;
    tick(1);
    chk("restart_fs", frame_start, 1);
    tick(12);
    rst = 1;
    tick(1);
    chk("rst_mid_ser_q", ser_q, 0);
    chk("rst_mid_fclk", fclk, 0);
    chk("rst_mid_fs", frame_start, 0);
    chk("rst_mid_ready", s_if.s_ready, 0);
    chk("rst_mid_frame_cnt", frame_cnt, 0);
    enable = 0; rst = 0;
    tick(2);

    // RAMP wrap on the 4-bit instance: 2 sync frames then ramp n = 0..17
    en2 = 1;
    tick(21*8);
    chk("w_count", c2a.size() >= 20, 1);
    chk("w_sync0", c2a[0], 8'hCC);
    chk("w_sync1", c2b[1], 8'hCC);
    for (int n = 0; n < 18; n++) begin
      chk($sformatf("w_ramp%0d_l0", n), c2a[2+n], {4'(n), 4'(n+1)});
      chk($sformatf("w_ramp%0d_l1", n), c2b[2+n], {4'(n+2), 4'(n+3)});
    end
    chk("w_wrap_lit", c2a[17], 8'hF0);
    chk("w_after_wrap_lit", c2a[18], 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
